pwr_rail_ctrl: RTL and testbench

Downstream stage of the power-init sequencer. Turns the six `pwr_init_step*` levels into registered rail-enable outputs and checks each rail's power-good feedback with debounce and a timeout. On a power fault it latches, drops all rails and holds the ROIC in reset. It also stretches the sequencer's one-cycle `roic_reset` pulse into an active-low ROIC reset of guaranteed width.

---
 rtl/pwr_rail_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pwr_rail_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_rail_ctrl.sv
// Rail-enable sequencing back end: registers pwr_init_step levels onto the rails,
// supervises power-good with timeout/fault latch and stretches the ROIC reset.
// Optional power-good supervision is enabled by defining PG_CHECK_EN.
module pwr_rail_ctrl #(
  parameter int          NUM_RAILS      = 6,
  parameter logic [24:0] PG_TIMEOUT     = 25'd200000,
  parameter int          DEBOUNCE       = 4,
  parameter int          ROIC_RST_WIDTH = 16
) (
  input  logic                         fsm_clk,
  input  logic                         reset_n,
  input  logic [NUM_RAILS-1:0]         step_req,
  input  logic [NUM_RAILS-1:0]         pg_in,
  input  logic                         roic_reset,
  input  logic                         fault_clr,
  output logic [NUM_RAILS-1:0]         rail_en,
  output logic                         rails_ok,
  output logic                         pwr_fault,
  output logic [$clog2(NUM_RAILS)-1:0] fault_rail,
  output logic                         roic_rst_n,
  output logic [2:0]                   ctrl_state
);

  // state  | meaning
  // IDLE   | all rails off, waiting for a step request
  // WAIT   | rails changed, waiting for power-good to follow (timeout armed)
  // STABLE | power-good matches the enables
  // FAULT  | timeout or brown-out latched, rails off, ROIC held in reset
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_FAULT  = 3'd3
  } state_t;

  localparam int FRW = $clog2(NUM_RAILS);
  localparam int SW  = $clog2(ROIC_RST_WIDTH + 1);

  state_t               state_q, state_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
  logic [24:0]          tmo_q, tmo_d;
  logic                 rails_ok_q, rails_ok_d;
  logic [SW-1:0]        stretch_q, stretch_d;
  logic                 roic_rst_n_q, roic_rst_n_d;
  logic [NUM_RAILS-1:0] pg_db;

`ifdef PG_CHECK_EN
  logic [NUM_RAILS-1:0]      pg_s1_q, pg_s2_q, pg_db_q;
  logic [NUM_RAILS-1:0][3:0] db_cnt_q;
  logic [FRW-1:0]            fault_idx;
  logic                      pwr_fault_q;
  logic [FRW-1:0]            fault_rail_q;

  always_ff @(posedge fsm_clk or negedge reset_n) begin
    if (!reset_n) begin
      pg_s1_q  <= '0;
      pg_s2_q  <= '0;
      pg_db_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      pg_s1_q <= pg_in;
      pg_s2_q <= pg_s1_q;
      for (int i = 0; i < NUM_RAILS; i++) begin
        if (pg_s2_q[i] != pg_db_q[i]) begin
          if (db_cnt_q[i] == 4'(DEBOUNCE - 1)) begin
            pg_db_q[i]  <= pg_s2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 4'd1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign pg_db = pg_db_q;

  // Descending scan so the lowest mismatching rail is the one left standing.
  always_comb begin
    fault_idx = '0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (pg_db[i] != rail_en_q[i]) fault_idx = FRW'(i);
    end
  end

  always_ff @(posedge fsm_clk or negedge reset_n) begin
    if (!reset_n) begin
      pwr_fault_q  <= 1'b0;
      fault_rail_q <= '0;
    end else if (state_q != ST_FAULT && state_d == ST_FAULT) begin
      pwr_fault_q  <= 1'b1;
      fault_rail_q <= fault_idx;
    end else if (state_q == ST_FAULT && state_d == ST_IDLE) begin
      pwr_fault_q  <= 1'b0;
    end
  end

  assign pwr_fault  = pwr_fault_q;
  assign fault_rail = fault_rail_q;
`else
  logic unused_pg;

  // Without supervision the rails are taken as good as soon as they are driven.
  assign pg_db      = rail_en_q;
  assign unused_pg  = ^pg_in;
  assign pwr_fault  = 1'b0;
  assign fault_rail = '0;
`endif

  always_comb begin
    state_d   = state_q;
    rail_en_d = rail_en_q;
    tmo_d     = tmo_q;
    case (state_q)
      ST_IDLE: begin
        rail_en_d = '0;
        if (step_req != '0) begin
          rail_en_d = step_req;
          tmo_d     = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmo_q != PG_TIMEOUT) tmo_d = tmo_q + 25'd1;
        if (step_req != rail_en_q) begin
          rail_en_d = step_req;
          tmo_d     = '0;
        end else if (pg_db == rail_en_q) begin
          state_d = (rail_en_q == '0) ? ST_IDLE : ST_STABLE;
        end else if (tmo_q == PG_TIMEOUT) begin
          rail_en_d = '0;
          state_d   = ST_FAULT;
        end
      end
      ST_STABLE: begin
        if (step_req != rail_en_q) begin
          rail_en_d = step_req;
          tmo_d     = '0;
          state_d   = ST_WAIT;
        end else if (pg_db != rail_en_q) begin
          rail_en_d = '0;
          state_d   = ST_FAULT;
        end
      end
      ST_FAULT: begin
        rail_en_d = '0;
        if (fault_clr && step_req == '0) state_d = ST_IDLE;
      end
      default: begin
        rail_en_d = '0;
        state_d   = ST_IDLE;
      end
    endcase

    rails_ok_d = (state_d == ST_STABLE) && (&rail_en_d);

    stretch_d = stretch_q;
    if (roic_reset)              stretch_d = SW'(ROIC_RST_WIDTH);
    else if (stretch_q != '0)    stretch_d = stretch_q - SW'(1);

    roic_rst_n_d = (stretch_d == '0) && (state_d != ST_FAULT);
  end

  // Stretch counter comes out of reset loaded so the ROIC sees a full-width reset.
  always_ff @(posedge fsm_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rail_en_q    <= '0;
      tmo_q        <= '0;
      rails_ok_q   <= 1'b0;
      stretch_q    <= SW'(ROIC_RST_WIDTH);
      roic_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rail_en_q    <= rail_en_d;
      tmo_q        <= tmo_d;
      rails_ok_q   <= rails_ok_d;
      stretch_q    <= stretch_d;
      roic_rst_n_q <= roic_rst_n_d;
    end
  end

  assign rail_en    = rail_en_q;
  assign rails_ok   = rails_ok_q;
  assign roic_rst_n = roic_rst_n_q;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_pwr_rail_ctrl.sv
// Scoreboard bench for pwr_rail_ctrl; expected snapshots are queued by the stimulus
// with a target cycle and checked by an independent negedge monitor.
module tb_pwr_rail_ctrl;

  localparam int GAP = 40;
`ifdef PG_CHECK_EN
  localparam int STB_LAT = 18;
  localparam int NEW_LAT = 8;
`else
  localparam int STB_LAT = 2;
  localparam int NEW_LAT = 3;
`endif

  localparam logic [14:0] M_ST  = 15'h7000;
  localparam logic [14:0] M_RE  = 15'h0FC0;
  localparam logic [14:0] M_OK  = 15'h0020;
  localparam logic [14:0] M_PF  = 15'h0010;
  localparam logic [14:0] M_FR  = 15'h000E;
  localparam logic [14:0] M_RN  = 15'h0001;
  localparam logic [14:0] M_ALL = 15'h7FFF;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_STABLE = 3'd2, S_FAULT = 3'd3;

  logic       fsm_clk = 1'b0;
  logic       reset_n;
  logic [5:0] step_req;
  logic [5:0] pg_in;
  logic       roic_reset;
  logic       fault_clr;
  logic [5:0] rail_en;
  logic       rails_ok;
  logic       pwr_fault;
  logic [2:0] fault_rail;
  logic       roic_rst_n;
  logic [2:0] ctrl_state;
  logic [14:0] obs;

  typedef struct {
    string       nm;
    int          cyc;
    logic [14:0] m;
    logic [14:0] e;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pwr_rail_ctrl #(
    .NUM_RAILS      (6),
    .PG_TIMEOUT     (25'd100),
    .DEBOUNCE       (4),
    .ROIC_RST_WIDTH (16)
  ) dut (
    .fsm_clk    (fsm_clk),
    .reset_n    (reset_n),
    .step_req   (step_req),
    .pg_in      (pg_in),
    .roic_reset (roic_reset),
    .fault_clr  (fault_clr),
    .rail_en    (rail_en),
    .rails_ok   (rails_ok),
    .pwr_fault  (pwr_fault),
    .fault_rail (fault_rail),
    .roic_rst_n (roic_rst_n),
    .ctrl_state (ctrl_state)
  );

  assign obs = {ctrl_state, rail_en, rails_ok, pwr_fault, fault_rail, roic_rst_n};

  always #5 fsm_clk = ~fsm_clk;

  initial forever begin
    @(posedge fsm_clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge fsm_clk);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        n_cmp++;
        if (q[i].cyc < cyc) begin
          n_bad++;
          $display("FAIL %s: check for cycle %0d missed (now %0d)", q[i].nm, q[i].cyc, cyc);
        end else if (((obs ^ q[i].e) & q[i].m) != 15'h0) begin
          n_bad++;
          $display("FAIL %s @%0d: got %h required %h (mask %h)",
                   q[i].nm, cyc, obs & q[i].m, q[i].e & q[i].m, q[i].m);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge fsm_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int at, input logic [14:0] m,
                     input logic [2:0] st, input logic [5:0] re, input logic ok,
                     input logic pf, input logic [2:0] fr, input logic rn);
    exp_t e;
    e.nm  = nm;
    e.cyc = at;
    e.m   = m;
    e.e   = {st, re, ok, pf, fr, rn};
    q.push_back(e);
  endtask

  task automatic ramp_step(input logic [5:0] v, input logic last);
    int k;
    k = cyc;
    step_req = v;
    chk("ramp_en",     k + 1,           M_ST | M_RE | M_PF | M_FR, S_WAIT,   v, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("ramp_wait",   k + STB_LAT - 1, M_ST | M_RE,               S_WAIT,   v, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("ramp_stable", k + STB_LAT,     M_ST | M_RE | M_OK | M_PF, S_STABLE, v, last, 1'b0, 3'd0, 1'b0);
    tick(11);
    pg_in = v;
    tick(GAP - 11);
  endtask

  initial begin
    int k;
    reset_n    = 1'b0;
    step_req   = '0;
    pg_in      = '0;
    roic_reset = 1'b0;
    fault_clr  = 1'b0;

    tick(3);
    chk("reset_state", cyc, M_ALL, S_IDLE, 6'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    reset_n = 1'b1;
    k = cyc;
    chk("post_rst_low",  k + 15, M_RN | M_ST, S_IDLE, 6'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("post_rst_high", k + 16, M_RN,        S_IDLE, 6'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick(20);

    // ROIC stretch with retrigger 8 cycles after the first pulse
    k = cyc;
    chk("roic_pre",  k,      M_RN, S_IDLE, 6'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("roic_n1",   k + 1,  M_RN, S_IDLE, 6'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("roic_n16",  k + 16, M_RN, S_IDLE, 6'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("roic_n17",  k + 17, M_RN, S_IDLE, 6'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("roic_n24",  k + 24, M_RN, S_IDLE, 6'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("roic_n25",  k + 25, M_RN, S_IDLE, 6'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    roic_reset = 1'b1;
    tick(1);
    roic_reset = 1'b0;
    tick(7);
    roic_reset = 1'b1;
    tick(1);
    roic_reset = 1'b0;
    tick(22);

    for (int i = 0; i < 6; i++) begin
      ramp_step(6'((1 << (i + 1)) - 1), (i == 5));
    end

`ifdef PG_CHECK_EN
    // 2-cycle glitch must be filtered, 10-cycle drop must fault
    k = cyc;
    pg_in[4] = 1'b0;
    chk("glitch_ignored", k + 12, M_ST | M_OK | M_PF, S_STABLE, 6'h3F, 1'b1, 1'b0, 3'd0, 1'b0);
    tick(2);
    pg_in[4] = 1'b1;
    tick(15);
    k = cyc;
    pg_in[4] = 1'b0;
    chk("brown_pre",   k + 6, M_ST | M_PF, S_STABLE, 6'h3F, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("brown_fault", k + 7, M_ALL,       S_FAULT,  6'h00, 1'b0, 1'b1, 3'd4, 1'b0);
    tick(10);
    pg_in[4] = 1'b1;
    tick(2);
    k = cyc;
    fault_clr = 1'b1;
    chk("clr_held", k + 3, M_ST | M_PF | M_FR | M_RN, S_FAULT, 6'h00, 1'b0, 1'b1, 3'd4, 1'b0);
    tick(5);
    k = cyc;
    step_req = '0;
    chk("clr_release", k + 1, M_ALL, S_IDLE, 6'h00, 1'b0, 1'b0, 3'd4, 1'b1);
    tick(2);
    fault_clr = 1'b0;
    pg_in = '0;
    tick(20);
`else
    k = cyc;
    step_req = '0;
    pg_in = '0;
    chk("down_wait", k + 1, M_ST | M_RE | M_OK | M_PF | M_FR, S_WAIT, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("down_idle", k + 2, M_ST | M_RE | M_OK,               S_IDLE, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(20);
`endif

    // Newest request wins while still in WAIT
    k = cyc;
    step_req = 6'h01;
    chk("newest_first",  k + 1,           M_ST | M_RE, S_WAIT,   6'h01, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("newest_reload", k + 2,           M_ST | M_RE, S_WAIT,   6'h03, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("newest_wait",   k + NEW_LAT - 1, M_ST | M_RE, S_WAIT,   6'h03, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("newest_stable", k + NEW_LAT,     M_ST | M_RE | M_OK, S_STABLE, 6'h03, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);
    step_req = 6'h03;
    pg_in    = 6'h03;
    tick(15);
    k = cyc;
    step_req = '0;
    pg_in    = '0;
    chk("newest_idle", k + 20, M_ST | M_RE | M_PF, S_IDLE, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(22);

`ifdef PG_CHECK_EN
    // Timeout on rail 2 with PG_TIMEOUT = 100
    k = cyc;
    step_req = 6'h04;
    chk("tmo_enter", k + 1,   M_ST | M_RE,        S_WAIT,  6'h04, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("tmo_edge",  k + 101, M_ST | M_RE | M_PF, S_WAIT,  6'h04, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("tmo_fault", k + 102, M_ALL,              S_FAULT, 6'h00, 1'b0, 1'b1, 3'd2, 1'b0);
    tick(105);
    k = cyc;
    fault_clr = 1'b1;
    chk("tmo_held", k + 3, M_ST | M_PF | M_FR | M_RN, S_FAULT, 6'h00, 1'b0, 1'b1, 3'd2, 1'b0);
    tick(5);
    k = cyc;
    step_req = '0;
    chk("tmo_release", k + 1, M_ALL, S_IDLE, 6'h00, 1'b0, 1'b0, 3'd2, 1'b1);
    tick(2);
    fault_clr = 1'b0;
    tick(3);
`endif

    // Asynchronous reset while in WAIT
    step_req = 6'h01;
    tick(1);
    reset_n = 1'b0;
    k = cyc;
    chk("async_rst",      k,     M_ALL, S_IDLE, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("async_rst_hold", k + 2, M_ALL, S_IDLE, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(3);
    reset_n  = 1'b1;
    step_req = '0;
    tick(5);

    foreach (q[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: check for cycle %0d never reached", q[i].nm, q[i].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
